// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver push, consumer pop and status signals of the RX byte FIFO
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  rx_data;
    logic        rx_data_ready;
    logic        flush;
    logic        rd_en;
    logic        clr_overflow;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        full;
    logic        almost_full;
    logic [AW:0] count;
    logic        overflow;
    modport master (
        output rx_data, rx_data_ready, flush, rd_en, clr_overflow,
        input  rd_data, rd_valid, full, almost_full, count, overflow
    );
    modport slave (
        input  rx_data, rx_data_ready, flush, rd_en, clr_overflow,
        output rd_data, rd_valid, full, almost_full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind the UART receiver with sticky overflow
module uart_rx_fifo #(
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C   = (AW+1)'(ALMOST_FULL_LEVEL);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, drop, is_full;

    assign is_full         = count_q == FULL_C;
    assign bus.rd_valid    = count_q != '0;
    assign bus.full        = is_full;
    assign bus.almost_full = count_q >= AF_C;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.rd_data     = bus.rd_valid ? mem[rd_ptr_q] : 8'h00;

    // Qualify requests; a flush swallows any same-cycle push or pop, and a full FIFO only
    // accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
        pop        = bus.rd_en & bus.rd_valid & ~bus.flush;
        push       = bus.rx_data_ready & ~bus.flush & (~is_full | pop);
        drop       = bus.rx_data_ready & ~bus.flush & is_full & ~pop;
        wr_ptr_d   = bus.flush ? '0 : push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = bus.flush ? '0 : pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = bus.flush ? '0 :
                     (push & ~pop) ? count_q + 1'b1 :
                     (pop & ~push) ? count_q - 1'b1 : count_q;
        overflow_d = drop ? 1'b1 : bus.clr_overflow ? 1'b0 : overflow_q;
    end

    // Pointer, occupancy and overflow state; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.rx_data;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver presents with its one-cycle data-ready strobe and holds the bytes in a circular FIFO. Bytes are exposed to the bus/CPU side through a first-word-fall-through read interface. It generates the full indication that feeds back to the receiver, plus an almost-full level and a sticky overflow flag.

Parameters:
DEPTH, 16, number of byte entries; power of two, at least 2; pointer width AW = log2(DEPTH) derived locally
ALMOST_FULL_LEVEL, 12, occupancy at or above which almost_full asserts; range 1..DEPTH

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
rx_data  input  8  byte from receiver; valid only when rx_data_ready=1
rx_data_ready  input  1  one-cycle strobe per received byte (push request)
flush  input  1  synchronous clear of FIFO contents
rd_en  input  1  pop request from consumer
clr_overflow  input  1  clears sticky overflow flag
rd_data  output  8  head-of-FIFO byte; 0 when empty
rd_valid  output  1  FIFO not empty
full  output  1  count == DEPTH; drives the receiver's rx_buf_full
almost_full  output  1  count >= ALMOST_FULL_LEVEL
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Next cycle: rd_valid=0, full=0, almost_full=0, rd_data=0. Memory contents are not reset.
- Storage: DEPTH x 8 array. Pointers are AW bits and wrap from DEPTH-1 to 0 naturally. count is tracked explicitly, not derived from the pointers.
- push = rx_data_ready. pop = rd_en & rd_valid. rd_en while empty is ignored; no pointer change, no error.
- Accepted push: mem[wr_ptr] <= rx_data; wr_ptr++.
- Accepted pop: rd_ptr++.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both push and pop occur, or when neither occurs.
- First-word fall-through:
  - rd_data = mem[rd_ptr] combinationally whenever rd_valid=1; rd_data = 0 when empty.
  - A byte pushed into an empty FIFO appears on rd_data with rd_valid=1 in the cycle after the push edge (latency 1).
  - After a pop, the next byte is presented the following cycle.
- Full with push and no pop: byte dropped; pointers and count unchanged; overflow <= 1.
- Full with simultaneous push and pop: both accepted; count stays DEPTH; overflow not set.
- Empty with simultaneous push and rd_en: push accepted, pop ignored; count becomes 1.
- overflow:
  - Stays set until clr_overflow=1.
  - If clr_overflow and a new drop occur in the same cycle, set wins (overflow=1).
  - Reset clears it; flush does not.
- flush:
  - wr_ptr=0, rd_ptr=0, count=0 at the next edge.
  - Any push or pop in the same cycle is discarded; overflow is not set by a flush-cycle push.
  - rst has priority over flush.
- full, almost_full and rd_valid are combinational decodes of the registered count, so they are valid from the cycle after each update.
- Back-pressure: the receiver is not stalled. full is advisory only; the drop-plus-overflow rule above governs.

Test Plan:
1. After reset, push 0xA5 -> next cycle rd_valid=1, rd_data=0xA5, count=1. Pulse rd_en -> next cycle rd_valid=0, rd_data=0, count=0.
2. Push 16 bytes 0x00..0x0F (DEPTH=16) -> almost_full=1 once count reaches 12, full=1 at count=16. Pop all 16 -> bytes read in order 0x00..0x0F, full=0, rd_valid=0 at the end.
3. Fill to 16, push 0x77 with no pop -> overflow=1, count=16, 0x77 never read. Pulse clr_overflow -> overflow=0. Repeat with clr_overflow and the drop in the same cycle -> overflow=1.
4. Fill to 16, push 0x55 with rd_en in the same cycle -> count=16, overflow=0, 0x55 is the last byte read after 16 pops.
5. Wrap-around: 40 interleaved push/pop cycles with random occupancy -> output byte stream matches the input stream exactly; count never exceeds 16.
6. With count=5 and overflow=1, assert flush together with a push -> count=0, rd_valid=0, overflow stays 1. Assert rst with flush -> all outputs at reset values.
